// File: rtl/instr_fetch.sv
// Two-byte instruction fetch unit: reads the opcode and operand bytes from a
// byte-wide memory, holds the instruction until decode takes it, then advances the PC by 2.
module instr_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pc_in,
    output logic [7:0]  pc_next,
    input  logic        flush,
    input  logic [7:0]  flush_pc,
    output logic        mem_req,
    output logic [7:0]  mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        dec_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t      state_q;
    logic        settle_q;
    logic [7:0]  fetch_pc_q;
    logic [7:0]  pc_next_q;
    logic [15:0] instr_q;
    logic        instr_valid_q;

    // IDLE spends two cycles so the external PC register can pick up pc_next
    // before it is sampled as the new fetch address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            settle_q      <= 1'b0;
            fetch_pc_q    <= 8'h00;
            pc_next_q     <= 8'h00;
            instr_q       <= 16'h0000;
            instr_valid_q <= 1'b0;
        end else if (flush) begin
            state_q       <= IDLE;
            settle_q      <= 1'b0;
            instr_valid_q <= 1'b0;
            pc_next_q     <= flush_pc;
        end else begin
            case (state_q)
                IDLE: begin
                    if (settle_q) begin
                        settle_q   <= 1'b0;
                        fetch_pc_q <= pc_in;
                        state_q    <= REQ_HI;
                    end else begin
                        settle_q <= 1'b1;
                    end
                end
                REQ_HI: begin
                    if (mem_ack) begin
                        instr_q[15:8] <= mem_rdata;
                        state_q       <= REQ_LO;
                    end
                end
                REQ_LO: begin
                    if (mem_ack) begin
                        instr_q[7:0]  <= mem_rdata;
                        instr_valid_q <= 1'b1;
                        state_q       <= HOLD;
                    end
                end
                HOLD: begin
                    if (dec_ready) begin
                        instr_valid_q <= 1'b0;
                        pc_next_q     <= fetch_pc_q + 8'd2;
                        settle_q      <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    settle_q <= 1'b0;
                end
            endcase
        end
    end

    // Request and address are decoded from state alone, so they stay put for
    // as long as memory withholds its acknowledge.
    always_comb begin
        mem_req  = 1'b0;
        mem_addr = fetch_pc_q;
        case (state_q)
            REQ_HI: mem_req = 1'b1;
            REQ_LO: begin
                mem_req  = 1'b1;
                mem_addr = fetch_pc_q + 8'd1;
            end
            default: begin
                mem_req  = 1'b0;
                mem_addr = fetch_pc_q;
            end
        endcase
    end

    assign pc_next     = pc_next_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: each vector drives one cycle of inputs and
// checks the outputs just after the following rising edge.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic [7:0]  pc_in;
    logic [7:0]  pc_next;
    logic        flush;
    logic [7:0]  flush_pc;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        dec_ready;

    int errors;
    int checks;
    int vidx;

    typedef struct {
        logic        rst;
        logic        fl;
        logic [7:0]  fl_pc;
        logic [7:0]  pc;
        logic        ack;
        logic [7:0]  rdata;
        logic        rdy;
        logic        e_req;
        logic [7:0]  e_addr;
        logic [15:0] e_instr;
        logic        e_valid;
        logic [7:0]  e_pcn;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .pc_next     (pc_next),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .dec_ready   (dec_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic fl, input logic [7:0] fl_pc,
                                input logic [7:0] pc, input logic ack, input logic [7:0] rdata,
                                input logic rdy, input logic e_req, input logic [7:0] e_addr,
                                input logic [15:0] e_instr, input logic e_valid,
                                input logic [7:0] e_pcn);
        vec_t v;
        v.rst = rst; v.fl = fl; v.fl_pc = fl_pc; v.pc = pc; v.ack = ack; v.rdata = rdata;
        v.rdy = rdy; v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr;
        v.e_valid = e_valid; v.e_pcn = e_pcn;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL vec%0d %s: got %h, expected %h", idx, name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        reset     = v.rst;
        flush     = v.fl;
        flush_pc  = v.fl_pc;
        pc_in     = v.pc;
        mem_ack   = v.ack;
        mem_rdata = v.rdata;
        dec_ready = v.rdy;
        @(posedge clk);
        #1;
        chk("mem_req",     vidx, {15'd0, mem_req},     {15'd0, v.e_req});
        chk("mem_addr",    vidx, {8'd0, mem_addr},     {8'd0, v.e_addr});
        chk("instr",       vidx, instr,                v.e_instr);
        chk("instr_valid", vidx, {15'd0, instr_valid}, {15'd0, v.e_valid});
        chk("pc_next",     vidx, {8'd0, pc_next},      {8'd0, v.e_pcn});
        $display("vec%0d rst=%b fl=%b ack=%b rdy=%b -> req=%b addr=%h instr=%h valid=%b pc_next=%h",
                 vidx, v.rst, v.fl, v.ack, v.rdy, mem_req, mem_addr, instr, instr_valid, pc_next);
        vidx++;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        vidx   = 0;

        // Fetch at 0x00 (A5,3C), wrap fetch at 0xFF with a 4-cycle decode stall,
        // ack ignored in IDLE, then a 3-cycle memory wait at 0x10.
        //                rst fl fpc    pc     ack rdata  rdy  req addr   instr      v  pcn
        vecs[0]  = mk(1, 0, 8'h00, 8'h00, 0, 8'h00, 0,   0, 8'h00, 16'h0000, 0, 8'h00);
        vecs[1]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 0,   0, 8'h00, 16'h0000, 0, 8'h00);
        vecs[2]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 0,   1, 8'h00, 16'h0000, 0, 8'h00);
        vecs[3]  = mk(0, 0, 8'h00, 8'h00, 1, 8'hA5, 0,   1, 8'h01, 16'hA500, 0, 8'h00);
        vecs[4]  = mk(0, 0, 8'h00, 8'h00, 1, 8'h3C, 1,   0, 8'h00, 16'hA53C, 1, 8'h00);
        vecs[5]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 1,   0, 8'h00, 16'hA53C, 0, 8'h02);
        vecs[6]  = mk(0, 0, 8'h00, 8'hFF, 0, 8'h00, 0,   0, 8'h00, 16'hA53C, 0, 8'h02);
        vecs[7]  = mk(0, 0, 8'h00, 8'hFF, 0, 8'h00, 0,   1, 8'hFF, 16'hA53C, 0, 8'h02);
        vecs[8]  = mk(0, 0, 8'h00, 8'hFF, 1, 8'h12, 0,   1, 8'h00, 16'h123C, 0, 8'h02);
        vecs[9]  = mk(0, 0, 8'h00, 8'hFF, 1, 8'h34, 0,   0, 8'hFF, 16'h1234, 1, 8'h02);
        vecs[10] = mk(0, 0, 8'h00, 8'hFF, 1, 8'h99, 0,   0, 8'hFF, 16'h1234, 1, 8'h02);
        vecs[11] = mk(0, 0, 8'h00, 8'hFF, 0, 8'h00, 0,   0, 8'hFF, 16'h1234, 1, 8'h02);
        vecs[12] = mk(0, 0, 8'h00, 8'hFF, 0, 8'h00, 0,   0, 8'hFF, 16'h1234, 1, 8'h02);
        vecs[13] = mk(0, 0, 8'h00, 8'hFF, 0, 8'h00, 1,   0, 8'hFF, 16'h1234, 0, 8'h01);
        vecs[14] = mk(0, 0, 8'h00, 8'h10, 1, 8'h77, 0,   0, 8'hFF, 16'h1234, 0, 8'h01);
        vecs[15] = mk(0, 0, 8'h00, 8'h10, 0, 8'h00, 0,   1, 8'h10, 16'h1234, 0, 8'h01);
        vecs[16] = mk(0, 0, 8'h00, 8'h10, 0, 8'h00, 0,   1, 8'h10, 16'h1234, 0, 8'h01);
        vecs[17] = mk(0, 0, 8'h00, 8'h10, 0, 8'h00, 0,   1, 8'h10, 16'h1234, 0, 8'h01);
        vecs[18] = mk(0, 0, 8'h00, 8'h10, 0, 8'h00, 0,   1, 8'h10, 16'h1234, 0, 8'h01);
        vecs[19] = mk(0, 0, 8'h00, 8'h10, 1, 8'h5A, 0,   1, 8'h11, 16'h5A34, 0, 8'h01);
        vecs[20] = mk(0, 0, 8'h00, 8'h10, 1, 8'hC3, 1,   0, 8'h10, 16'h5AC3, 1, 8'h01);
        vecs[21] = mk(0, 0, 8'h00, 8'h10, 0, 8'h00, 1,   0, 8'h10, 16'h5AC3, 0, 8'h12);

        reset = 1'b1; flush = 1'b0; flush_pc = 8'h00; pc_in = 8'h00;
        mem_ack = 1'b0; mem_rdata = 8'h00; dec_ready = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i]);
        end

        // Flush in REQ_LO with a simultaneous ack: byte dropped, redirect to 0x40.
        apply(mk(0, 0, 8'h00, 8'h20, 0, 8'h00, 0,   0, 8'h10, 16'h5AC3, 0, 8'h12));
        apply(mk(0, 0, 8'h00, 8'h20, 0, 8'h00, 0,   1, 8'h20, 16'h5AC3, 0, 8'h12));
        apply(mk(0, 0, 8'h00, 8'h20, 1, 8'h11, 0,   1, 8'h21, 16'h11C3, 0, 8'h12));
        apply(mk(0, 1, 8'h40, 8'h20, 1, 8'h22, 1,   0, 8'h20, 16'h11C3, 0, 8'h40));
        apply(mk(0, 0, 8'h00, 8'h40, 0, 8'h00, 0,   0, 8'h20, 16'h11C3, 0, 8'h40));
        apply(mk(0, 0, 8'h00, 8'h40, 0, 8'h00, 0,   1, 8'h40, 16'h11C3, 0, 8'h40));

        // Reset together with flush while in HOLD: reset wins, pc_next goes to 0x00.
        apply(mk(0, 0, 8'h00, 8'h40, 1, 8'h66, 0,   1, 8'h41, 16'h66C3, 0, 8'h40));
        apply(mk(0, 0, 8'h00, 8'h40, 1, 8'h77, 0,   0, 8'h40, 16'h6677, 1, 8'h40));
        apply(mk(1, 1, 8'h40, 8'h40, 1, 8'h88, 1,   0, 8'h00, 16'h0000, 0, 8'h00));
        apply(mk(0, 0, 8'h00, 8'h08, 0, 8'h00, 0,   0, 8'h00, 16'h0000, 0, 8'h00));
        apply(mk(0, 0, 8'h00, 8'h08, 0, 8'h00, 0,   1, 8'h08, 16'h0000, 0, 8'h00));

        // Flush beats a transfer in HOLD: pc_next takes flush_pc, not fetch_pc+2.
        apply(mk(0, 0, 8'h00, 8'h08, 1, 8'hAA, 0,   1, 8'h09, 16'hAA00, 0, 8'h00));
        apply(mk(0, 0, 8'h00, 8'h08, 1, 8'hBB, 0,   0, 8'h08, 16'hAABB, 1, 8'h00));
        apply(mk(0, 1, 8'h80, 8'h08, 0, 8'h00, 1,   0, 8'h08, 16'hAABB, 0, 8'h80));
        apply(mk(0, 0, 8'h00, 8'h80, 0, 8'h00, 0,   0, 8'h08, 16'hAABB, 0, 8'h80));
        apply(mk(0, 0, 8'h00, 8'h80, 0, 8'h00, 0,   1, 8'h80, 16'hAABB, 0, 8'h80));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
